// File: rtl/collision_sweeper.sv
// rtl/collision_sweeper.sv - one collision pass over the lattice BRAM, feeding collision and writing results back
// Optional: define COLLISION_SWEEP_SKIP_BORDER_EN to skip border cells.
module collision_sweeper #(
    parameter int WIDTH        = 160,
    parameter int HEIGHT       = 120,
    parameter int ADDR_W       = 15,
    parameter int BRAM_LATENCY = 2,
    parameter int MAX_INFLIGHT = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    output logic [ADDR_W-1:0]     rd_addr_out,
    input  logic [8:0][7:0]       rd_data_in,
    output logic [ADDR_W-1:0]     wr_addr_out,
    output logic [8:0][7:0]       wr_data_out,
    output logic                  wr_en_out,
    output logic [8:0][7:0]       coll_data_out,
    output logic                  coll_valid_out,
    input  logic [8:0][7:0]       coll_data_in,
    input  logic                  coll_done_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  err_out
);
    localparam int NUM_CELLS = WIDTH * HEIGHT;
    localparam int PTR_W     = $clog2(MAX_INFLIGHT);
    localparam int CNT_W     = $clog2(MAX_INFLIGHT + 1);
    localparam int COL_W     = $clog2(WIDTH + 1);
    localparam int ROW_W     = $clog2(HEIGHT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                  state, state_nx;
    logic [ADDR_W-1:0]       addr;
    logic [COL_W-1:0]        col;
    logic [ROW_W-1:0]        row;
    logic [CNT_W-1:0]        inflight;
    logic [CNT_W-1:0]        fifo_cnt;
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [ADDR_W-1:0]       fifo_mem [MAX_INFLIGHT];
    logic [BRAM_LATENCY-1:0] tag;
    logic                    border, step, issue, last, fifo_empty, pop;

`ifdef COLLISION_SWEEP_SKIP_BORDER_EN
    assign border = (row == '0) || (row == ROW_W'(HEIGHT - 1)) ||
                    (col == '0) || (col == COL_W'(WIDTH - 1));
`else
    assign border = 1'b0;
`endif

    // Border cells step the counter without consuming an inflight slot.
    assign step       = (state == ISSUE) && (border || (inflight < CNT_W'(MAX_INFLIGHT)));
    assign issue      = step && !border;
    assign last       = (addr == ADDR_W'(NUM_CELLS - 1));
    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = coll_done_in && !fifo_empty;
    assign rd_addr_out = addr;

    always_ff @(posedge clk_in) begin
        if (issue) begin
            fifo_mem[wr_ptr] <= addr;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= IDLE;
            addr           <= '0;
            col            <= '0;
            row            <= '0;
            inflight       <= '0;
            fifo_cnt       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            tag            <= '0;
            coll_data_out  <= '0;
            coll_valid_out <= 1'b0;
            wr_addr_out    <= '0;
            wr_data_out    <= '0;
            wr_en_out      <= 1'b0;
            err_out        <= 1'b0;
        end else begin
            state <= state_nx;
            if ((state == IDLE) && start_in) begin
                addr <= '0;
                col  <= '0;
                row  <= '0;
            end else if (step && !last) begin
                addr <= addr + 1'b1;
                if (col == COL_W'(WIDTH - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            tag[0] <= issue;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                tag[i] <= tag[i-1];
            end
            coll_valid_out <= tag[BRAM_LATENCY-1];
            if (tag[BRAM_LATENCY-1]) begin
                coll_data_out <= rd_data_in;
            end

            // Results come back in issue order, so the FIFO head names the destination.
            wr_en_out <= pop;
            if (pop) begin
                wr_addr_out <= fifo_mem[rd_ptr];
                wr_data_out <= coll_data_in;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            if (issue) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            fifo_cnt <= fifo_cnt + CNT_W'(issue) - CNT_W'(pop);
            inflight <= inflight + CNT_W'(issue) - CNT_W'(wr_en_out);
            if (coll_done_in && fifo_empty) begin
                err_out <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        busy_out = 1'b0;
        done_out = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) state_nx = ISSUE;
            end
            ISSUE: begin
                busy_out = 1'b1;
                if (step && last) state_nx = DRAIN;
            end
            DRAIN: begin
                busy_out = 1'b1;
                if (inflight == '0) state_nx = DONE;
            end
            DONE: begin
                busy_out = 1'b1;
                done_out = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
